// File: rtl/x_y_pkg.sv
// x_y_pkg: shared widths, depth and slot tag constants for the x/y splitter
package x_y_pkg;
  localparam int DATA_W = 16;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic SLOT_X = 1'b1;
  localparam logic SLOT_Y = 1'b0;
endpackage

// File: rtl/xy_sync_fifo.sv
// xy_sync_fifo: count-based FWFT buffer (wr_en/wr_data push, rd_en pops if non-empty, rd_data head, empty/full status)
module xy_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_rd;
  assign do_rd = rd_en & ~empty;
  assign rd_data = mem[rp];
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + PW'(1);
      end
      if (do_rd) rp <= rp + PW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/x_y_splitter.sv
// x_y_splitter: routes tagged bus words (din_valid/sel_x/din_x_y) into x and y FWFT buffers (rd_*/dout_*/empty_*/full_*), counts x-then-y pairs, flags seq_err/ovf_err
module x_y_splitter
  import x_y_pkg::*;
#(
  parameter int DATA_W = x_y_pkg::DATA_W,
  parameter int DEPTH = x_y_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              sel_x,
  input  logic [DATA_W-1:0] din_x_y,
  input  logic              rd_x,
  input  logic              rd_y,
  output logic [DATA_W-1:0] dout_x,
  output logic [DATA_W-1:0] dout_y,
  output logic              empty_x,
  output logic              empty_y,
  output logic              full_x,
  output logic              full_y,
  output logic [7:0]        pair_cnt,
  output logic              seq_err,
  output logic              ovf_err
);
  logic to_x, to_y, wr_x, wr_y, drop, dup, pair, last_sel, seen;
  assign to_x = din_valid & (sel_x == SLOT_X);
  assign to_y = din_valid & (sel_x == SLOT_Y);
  assign wr_x = to_x & (~full_x | rd_x);
  assign wr_y = to_y & (~full_y | rd_y);
  assign drop = (to_x & ~wr_x) | (to_y & ~wr_y);
  assign dup = din_valid & seen & (sel_x == last_sel);
  assign pair = to_y & seen & (last_sel == SLOT_X);
  xy_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_x (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_x), .wr_data(din_x_y), .rd_en(rd_x),
    .rd_data(dout_x), .empty(empty_x), .full(full_x)
  );
  xy_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_y (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_y), .wr_data(din_x_y), .rd_en(rd_y),
    .rd_data(dout_y), .empty(empty_y), .full(full_y)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_sel <= SLOT_Y;
      seen <= 1'b0;
      pair_cnt <= '0;
      seq_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (din_valid) begin
        last_sel <= sel_x;
        seen <= 1'b1;
      end
      if (pair) pair_cnt <= pair_cnt + 8'd1;
      seq_err <= seq_err | dup;
      ovf_err <= ovf_err | drop;
    end
  end
endmodule

// File: tb/tb_x_y_splitter.sv
// tb_x_y_splitter: directed scoreboard bench for x_y_splitter
module tb_x_y_splitter;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din_valid = 1'b0;
  logic sel_x = 1'b0;
  logic [DW-1:0] din_x_y = '0;
  logic rd_x = 1'b0;
  logic rd_y = 1'b0;
  logic [DW-1:0] dout_x, dout_y;
  logic empty_x, empty_y, full_x, full_y, seq_err, ovf_err;
  logic [7:0] pair_cnt;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qx[$];
  logic [DW-1:0] qy[$];
  logic m_seen, m_last, m_seq, m_ovf;
  logic [7:0] m_pair;
  x_y_splitter dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .sel_x(sel_x), .din_x_y(din_x_y),
    .rd_x(rd_x), .rd_y(rd_y), .dout_x(dout_x), .dout_y(dout_y),
    .empty_x(empty_x), .empty_y(empty_y), .full_x(full_x), .full_y(full_y),
    .pair_cnt(pair_cnt), .seq_err(seq_err), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("empty_x", 32'(empty_x), 32'(qx.size() == 0));
    chk("empty_y", 32'(empty_y), 32'(qy.size() == 0));
    chk("full_x", 32'(full_x), 32'(qx.size() == DEPTH));
    chk("full_y", 32'(full_y), 32'(qy.size() == DEPTH));
    chk("pair_cnt", 32'(pair_cnt), 32'(m_pair));
    chk("seq_err", 32'(seq_err), 32'(m_seq));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (qx.size() != 0) chk("dout_x", 32'(dout_x), 32'(qx[0]));
    if (qy.size() != 0) chk("dout_y", 32'(dout_y), 32'(qy[0]));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    rd_x = 1'b0;
    rd_y = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qx.delete();
    qy.delete();
    m_seen = 1'b0;
    m_last = 1'b0;
    m_seq = 1'b0;
    m_ovf = 1'b0;
    m_pair = 8'd0;
    check_all();
    chk("rst_dout_x", 32'(dout_x), 32'h0);
    chk("rst_dout_y", 32'(dout_y), 32'h0);
  endtask
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d, input logic rx, input logic ry);
    logic pop_x, pop_y;
    din_valid = v;
    sel_x = s;
    din_x_y = d;
    rd_x = rx;
    rd_y = ry;
    pop_x = rx && qx.size() != 0;
    pop_y = ry && qy.size() != 0;
    if (pop_x) void'(qx.pop_front());
    if (pop_y) void'(qy.pop_front());
    if (v) begin
      if (m_seen && s == m_last) m_seq = 1'b1;
      if (m_seen && m_last && !s) m_pair++;
      m_last = s;
      m_seen = 1'b1;
      if (s) begin
        if (qx.size() < DEPTH) qx.push_back(d);
        else m_ovf = 1'b1;
      end else begin
        if (qy.size() < DEPTH) qy.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sel_x = ~s;
    rd_x = 1'b0;
    rd_y = 1'b0;
    check_all();
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    step(0, 1, 16'h0, 0, 1);
    step(1, 0, 16'h0300, 0, 0);
    chk("first_y_seq", 32'(seq_err), 32'h0);
    chk("first_y_pair", 32'(pair_cnt), 32'h0);
    do_reset();
    step(1, 1, 16'h0001, 0, 0);
    step(1, 0, 16'h0100, 0, 0);
    step(1, 1, 16'h0002, 0, 0);
    step(1, 0, 16'h0200, 0, 0);
    chk("alt_dout_x", 32'(dout_x), 32'h0001);
    chk("alt_dout_y", 32'(dout_y), 32'h0100);
    chk("alt_pair", 32'(pair_cnt), 32'd2);
    step(0, 0, 16'h0, 1, 0);
    chk("alt_pop_x", 32'(dout_x), 32'h0002);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 16'(16'h0010 + i), 0, 0);
      if (i == 3) chk("ovf_full_x", 32'(full_x), 32'h1);
      if (i < 4) step(1, 0, 16'(16'h0700 + i), 0, 0);
    end
    chk("ovf_flag", 32'(ovf_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_read", 32'(dout_x), 32'(16'h0010 + i));
      step(0, 0, 16'h0, 1, 0);
    end
    chk("ovf_empty_x", 32'(empty_x), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 16'(16'h0020 + i), 0, 0);
      if (i < 3) step(1, 0, 16'(16'h0800 + i), 0, 0);
    end
    step(1, 0, 16'h0803, 0, 0);
    step(1, 1, 16'h00AA, 1, 0);
    chk("rw_full_x", 32'(full_x), 32'h1);
    chk("rw_ovf", 32'(ovf_err), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1, 0);
    chk("rw_last_aa_gone", 32'(empty_x), 32'h1);
    do_reset();
    step(1, 1, 16'h0005, 0, 0);
    step(1, 1, 16'h0006, 0, 0);
    chk("seq_set", 32'(seq_err), 32'h1);
    chk("seq_pair0", 32'(pair_cnt), 32'h0);
    step(0, 0, 16'h0, 1, 0);
    chk("seq_second", 32'(dout_x), 32'h0006);
    step(1, 0, 16'h0007, 0, 0);
    chk("seq_pair1", 32'(pair_cnt), 32'h1);
    do_reset();
    step(1, 1, 16'h0031, 0, 0);
    step(1, 1, 16'h0032, 0, 0);
    step(1, 0, 16'h0041, 0, 0);
    step(1, 1, 16'h0033, 0, 0);
    step(1, 0, 16'h0042, 0, 0);
    step(1, 1, 16'h0034, 0, 0);
    step(1, 1, 16'h0035, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    chk("mid_flags", 32'({seq_err, ovf_err}), 32'h3);
    do_reset();
    step(1, 1, 16'h0051, 0, 0);
    step(1, 0, 16'h0061, 0, 0);
    chk("post_rst_seq", 32'(seq_err), 32'h0);
    chk("post_rst_pair", 32'(pair_cnt), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/x_y_splitter.md
# x_y_splitter

Receive-side counterpart of the time-multiplexed x/y product channel. Accepts one 16-bit word per valid cycle on a shared bus, tagged by `sel_x` (1 = x slot, 0 = y slot), and de-interleaves it into two independent FWFT buffers, one for x and one for y. Checks that slots strictly alternate and that no word is lost, reporting both conditions on sticky error flags. Sits downstream of the shared-multiplier producer and feeds per-channel consumers at their own read pace.

## Interface
- `DATA_W`, 16, word width of the shared bus and both output channels
- `DEPTH`, 4, entries per channel buffer; power of two, at least 2

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `din_valid`  in  1  bus word present this cycle
- `sel_x`  in  1  slot tag of the bus word: 1 = x, 0 = y
- `din_x_y`  in  DATA_W  shared bus word
- `rd_x`  in  1  pop the x head
- `rd_y`  in  1  pop the y head
- `dout_x`  out  DATA_W  x head word, valid when `empty_x` = 0
- `dout_y`  out  DATA_W  y head word, valid when `empty_y` = 0
- `empty_x`, `empty_y`  out  1  channel holds no words
- `full_x`, `full_y`  out  1  channel holds DEPTH words
- `pair_cnt`  out  8  count of completed x-then-y pairs, wraps 255 -> 0
- `seq_err`  out  1  sticky: two consecutive valid words carried the same tag
- `ovf_err`  out  1  sticky: a word was dropped because its channel was full

## Operation
- Routing: a word with `din_valid`=1 goes to the x buffer when `sel_x`=1 and to the y buffer when `sel_x`=0. Cycles with `din_valid`=0 are ignored entirely, and `sel_x` is don't-care in those cycles.
- Write acceptance: the word is stored if the target channel is not full, or if it is full and the same channel is read in the same cycle (a simultaneous pop-and-push leaves the count unchanged). Otherwise the word is dropped and `ovf_err` is set.
- Read: `rd_*` while the channel is non-empty pops the head. `rd_*` while empty is ignored and sets no flag. The two channels operate fully independently.
- Sequence tracking (`last_sel`, `seen`):
  - After reset `seen`=0, and the first valid word is always legal, whatever its tag.
  - Afterwards, a valid word whose tag equals `last_sel` sets `seq_err`. The word is still routed and stored; the flag is informational only.
  - Every valid word updates `last_sel` and sets `seen`.
- Pair counting: `pair_cnt` increments on a valid y word whose predecessor valid word was x (`seen`=1, `last_sel`=1). Dropped words still count, because tracking uses tags, not storage.
- Sticky flags clear only on reset.
- Reset mid-operation: both buffers are flushed, pointers and counts go to zero, and all tracking state and flags clear. Words in flight at the reset edge are discarded.

## Timing
- Reset values: `empty_x`=`empty_y`=1, `full_x`=`full_y`=0, `pair_cnt`=0, `seq_err`=`ovf_err`=0, `dout_x`=`dout_y`=0.
- Write latency: a word accepted at edge N appears on `dout_*` with `empty_*`=0 after edge N (visible in cycle N+1). The output is FWFT, with no read needed to present the head.
- Read latency: a pop at edge N presents the next head, or `empty_*`=1, after edge N.
- `full_*` asserts after the edge that makes count = DEPTH and deasserts after the first pop.
- Error flags and `pair_cnt` update at the same edge as the offending or completing word.
- No combinational path from inputs to outputs. `dout_*` is either a registered head or a RAM read at the registered pointer.

## Structure
- Package `x_y_pkg`:
  - `DATA_W` default
  - `DEPTH` default
  - `PTR_W` = clog2(DEPTH)
  - constants `SLOT_X`=1'b1 and `SLOT_Y`=1'b0
- Sub-module `xy_sync_fifo` (params DATA_W, DEPTH):
  - instanced twice, once for x and once for y
  - ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`
  - count-based, with pointers wrapping at DEPTH
- Top level holds the routing, acceptance, sequence tracker, pair counter and sticky flags.

## Test plan
- Alternating stream: x=0x0001, y=0x0100, x=0x0002, y=0x0200, no reads → `dout_x`=0x0001, `dout_y`=0x0100, `pair_cnt`=2, both errors 0. Popping x once then gives `dout_x`=0x0002.
- Overflow: 5 x words 0x0010..0x0014 alternating with y words, DEPTH=4, no reads → `full_x`=1 after the 4th x word, the 5th is dropped, `ovf_err`=1. Four reads return 0x0010..0x0013, then `empty_x`=1.
- Full with simultaneous read: x full, x word 0x00AA arrives with `rd_x`=1 → word accepted, `ovf_err` stays 0, `full_x` stays 1, and 0x00AA is read last.
- Sequence error: x=0x0005 followed by x=0x0006 → `seq_err`=1 after the second word, both words stored, `pair_cnt` unchanged. A following y word increments `pair_cnt` to 1.
- Empty read and first-word legality: `rd_y` pulsed on an empty channel → no change. The first word after reset is a y word → no `seq_err` and no pair counted.
- Mid-operation reset: with 3 x and 2 y words held and both flags set, hold `rst_n`=0 for one edge → every output returns to its reset value. The next word is treated as the first word after reset.
